// File: rtl/multicycle_ctrl.sv
// Multicycle CPU main control FSM.
// Walks each instruction through IF/ID/EX/MEM/WB, issues the per-phase
// strobes, stalls on mem_ready, squashes writeback on signed overflow and
// counts retired instructions.
//
// state | meaning
// ------+-----------------------------------------------------------
// IF    | fetch: mem_rd, load IR/PC (+4) when memory is ready
// ID    | decode: latch op/funct, jump retires here, illegal pulses
// EX    | execute: ALU controls, beq resolves, overflow captured
// MEM   | lw/sw data access, held until mem_ready
// WB    | register-file write (suppressed on captured overflow)
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             overflow,
   input  logic             mem_ready,
   output logic [2:0]       state,
   output logic             pc_wr,
   output logic [1:0]       pc_src,
   output logic             ir_wr,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             reg_wr,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src,
   output logic [2:0]       alu_op,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_SLT = 3'd4;

   state_t           r_state;
   state_t           w_next;
   logic [5:0]       r_op;
   logic [5:0]       r_funct;
   logic             r_ovf;
   logic [CNT_W-1:0] r_retired;
   logic             w_retire;

   function automatic logic f_legal(input logic [5:0] f_op, input logic [5:0] f_fn);
      logic ok;
      ok = 1'b0;
      case (f_op)
         OP_RTYPE: ok = (f_fn == F_ADD) || (f_fn == F_SUB) || (f_fn == F_AND) ||
                        (f_fn == F_OR)  || (f_fn == F_SLT);
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [2:0] f_rtype_alu(input logic [5:0] f_fn);
      logic [2:0] a;
      case (f_fn)
         F_SUB:   a = ALU_SUB;
         F_AND:   a = ALU_AND;
         F_OR:    a = ALU_OR;
         F_SLT:   a = ALU_SLT;
         default: a = ALU_ADD;
      endcase
      return a;
   endfunction

   // ID decides from the freshly loaded IR; EX onward uses the latched copy.
   logic w_id_j;
   logic w_id_legal;
   logic w_is_r;
   logic w_is_lw;
   logic w_is_sw;
   logic w_is_beq;
   logic w_is_addi;
   logic w_is_ori;
   logic w_ovf_sig;

   assign w_id_j     = (op == OP_J);
   assign w_id_legal = f_legal(op, funct);
   assign w_is_r     = (r_op == OP_RTYPE);
   assign w_is_lw    = (r_op == OP_LW);
   assign w_is_sw    = (r_op == OP_SW);
   assign w_is_beq   = (r_op == OP_BEQ);
   assign w_is_addi  = (r_op == OP_ADDI);
   assign w_is_ori   = (r_op == OP_ORI);
   // Only signed add/sub style ops may squash writeback on overflow.
   assign w_ovf_sig  = w_is_addi || (w_is_r && ((r_funct == F_ADD) || (r_funct == F_SUB)));

   // State register, decode latch, overflow capture and retire counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IF;
         r_op      <= '0;
         r_funct   <= '0;
         r_ovf     <= 1'b0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_ID) begin
            r_op    <= op;
            r_funct <= funct;
         end
         if (r_state == S_EX) begin
            r_ovf <= overflow & w_ovf_sig;
         end
         if (w_retire) begin
            r_retired <= r_retired + 1'b1;
         end
      end
   end

   // Next-state and strobe decode; every strobe is forced low during reset.
   always_comb begin
      w_next     = r_state;
      w_retire   = 1'b0;
      pc_wr      = 1'b0;
      pc_src     = 2'd0;
      ir_wr      = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      reg_wr     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      illegal    = 1'b0;
      case (r_state)
         S_IF: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               ir_wr  = 1'b1;
               pc_wr  = 1'b1;
               w_next = S_ID;
            end
         end
         S_ID: begin
            if (!w_id_legal) begin
               illegal = 1'b1;
               w_next  = S_IF;
            end else if (w_id_j) begin
               pc_wr    = 1'b1;
               pc_src   = 2'd2;
               w_next   = S_IF;
               w_retire = 1'b1;
            end else begin
               w_next = S_EX;
            end
         end
         S_EX: begin
            alu_src    = w_is_lw || w_is_sw || w_is_addi || w_is_ori;
            reg_dst    = w_is_r;
            mem_to_reg = w_is_lw;
            if (w_is_r) begin
               alu_op = f_rtype_alu(r_funct);
            end else if (w_is_beq) begin
               alu_op = ALU_SUB;
            end else if (w_is_ori) begin
               alu_op = ALU_OR;
            end
            if (w_is_beq) begin
               pc_wr    = zero;
               pc_src   = 2'd1;
               w_next   = S_IF;
               w_retire = 1'b1;
            end else if (w_is_lw || w_is_sw) begin
               w_next = S_MEM;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM: begin
            if (w_is_lw) begin
               mem_rd = 1'b1;
               if (mem_ready) begin
                  w_next = S_WB;
               end
            end else begin
               mem_wr = 1'b1;
               if (mem_ready) begin
                  w_next   = S_IF;
                  w_retire = 1'b1;
               end
            end
         end
         S_WB: begin
            reg_wr     = !r_ovf;
            reg_dst    = w_is_r;
            mem_to_reg = w_is_lw;
            w_next     = S_IF;
            w_retire   = 1'b1;
         end
         default: begin
            w_next = S_IF;
         end
      endcase
      if (rst) begin
         w_retire   = 1'b0;
         pc_wr      = 1'b0;
         pc_src     = 2'd0;
         ir_wr      = 1'b0;
         mem_rd     = 1'b0;
         mem_wr     = 1'b0;
         reg_wr     = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         alu_src    = 1'b0;
         alu_op     = ALU_ADD;
         illegal    = 1'b0;
      end
   end

   assign state   = r_state;
   assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases from the test plan,
// then randomized instructions with random memory stalls, each compared
// cycle by cycle against an instruction-level reference model.
module tb_multicycle_ctrl;

   localparam int CW = 4;

   localparam int C_R    = 0;
   localparam int C_LW   = 1;
   localparam int C_SW   = 2;
   localparam int C_BEQ  = 3;
   localparam int C_ADDI = 4;
   localparam int C_ORI  = 5;
   localparam int C_J    = 6;
   localparam int C_ILL  = 7;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [5:0]    op = '0;
   logic [5:0]    funct = '0;
   logic          zero = 1'b0;
   logic          overflow = 1'b0;
   logic          mem_ready = 1'b0;
   logic [2:0]    state;
   logic          pc_wr;
   logic [1:0]    pc_src;
   logic          ir_wr;
   logic          mem_rd;
   logic          mem_wr;
   logic          reg_wr;
   logic          reg_dst;
   logic          mem_to_reg;
   logic          alu_src;
   logic [2:0]    alu_op;
   logic          illegal;
   logic [CW-1:0] retired;

   multicycle_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
      .overflow(overflow), .mem_ready(mem_ready), .state(state),
      .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .reg_wr(reg_wr), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
      .illegal(illegal), .retired(retired)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int exp_ret = 0;

   logic [13:0] obs;
   assign obs = {pc_wr, pc_src, ir_wr, mem_rd, mem_wr, reg_wr, reg_dst,
                 mem_to_reg, alu_src, alu_op, illegal};

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // R-type funct codes, indexed by the ALU op they select.
   function automatic logic [5:0] r_funct(input int idx);
      logic [5:0] t [5];
      t[0] = 6'b100000; t[1] = 6'b100010; t[2] = 6'b100100;
      t[3] = 6'b100101; t[4] = 6'b101010;
      return t[idx];
   endfunction

   function automatic logic [11:0] encode(input int cls, input int v);
      logic [5:0] o;
      logic [5:0] f;
      logic [5:0] bad [4];
      bad[0] = 6'h3f; bad[1] = 6'h01; bad[2] = 6'h05; bad[3] = 6'h3e;
      f = 6'($urandom);
      case (cls)
         C_R:    begin o = 6'b000000; f = r_funct(v); end
         C_LW:   o = 6'b100011;
         C_SW:   o = 6'b101011;
         C_BEQ:  o = 6'b000100;
         C_ADDI: o = 6'b001000;
         C_ORI:  o = 6'b001101;
         C_J:    o = 6'b000010;
         default: begin
            if (v < 4) o = bad[v];
            else begin o = 6'b000000; f = 6'b100001; end
         end
      endcase
      return {o, f};
   endfunction

   // Expected strobes for one phase of an instruction of class cls.
   function automatic logic [13:0] exp_vec(input int ph, input int cls, input int v,
                                           input bit mr, input bit z, input bit ov);
      logic pcw, irw, mrd, mwr, rw, rdst, m2r, asrc, ill;
      logic [1:0] psrc;
      logic [2:0] aop;
      {pcw, irw, mrd, mwr, rw, rdst, m2r, asrc, ill} = '0;
      psrc = 0; aop = 0;
      case (ph)
         0: begin mrd = 1; if (mr) begin irw = 1; pcw = 1; end end
         1: begin
            if (cls == C_J) begin pcw = 1; psrc = 2; end
            if (cls == C_ILL) ill = 1;
         end
         2: begin
            asrc = (cls == C_LW || cls == C_SW || cls == C_ADDI || cls == C_ORI);
            aop  = (cls == C_R) ? 3'(v) : (cls == C_BEQ) ? 3'd1 : (cls == C_ORI) ? 3'd3 : 3'd0;
            if (cls == C_BEQ) begin pcw = z; psrc = 1; end
            rdst = (cls == C_R);
            m2r  = (cls == C_LW);
         end
         3: begin if (cls == C_LW) mrd = 1; else mwr = 1; end
         4: begin
            rw   = !(ov && (cls == C_ADDI || (cls == C_R && v < 2)));
            rdst = (cls == C_R);
            m2r  = (cls == C_LW);
         end
         default: ;
      endcase
      return {pcw, psrc, irw, mrd, mwr, rw, rdst, m2r, asrc, aop, ill};
   endfunction

   // Run one instruction from IF to its return to IF, checking every cycle.
   task automatic run_instr(input int cls, input int v, input int if_st,
                            input int mem_st, input bit z, input bit ov);
      int ph[$];
      bit mrq[$];
      logic [11:0] enc;
      enc = encode(cls, v);
      op = enc[11:6]; funct = enc[5:0]; zero = z; overflow = ov;
      for (int i = 0; i < if_st; i++) begin ph.push_back(0); mrq.push_back(0); end
      ph.push_back(0); mrq.push_back(1);
      ph.push_back(1); mrq.push_back(1'($urandom));
      if (cls != C_J && cls != C_ILL) begin ph.push_back(2); mrq.push_back(1'($urandom)); end
      if (cls == C_LW || cls == C_SW) begin
         for (int i = 0; i < mem_st; i++) begin ph.push_back(3); mrq.push_back(0); end
         ph.push_back(3); mrq.push_back(1);
      end
      if (cls == C_R || cls == C_ADDI || cls == C_ORI || cls == C_LW) begin
         ph.push_back(4); mrq.push_back(1'($urandom));
      end
      foreach (ph[i]) begin
         mem_ready = mrq[i];
         @(negedge clk);
         chk($sformatf("state c%0d cyc%0d", cls, i), int'(state), ph[i]);
         chk($sformatf("strobes c%0d cyc%0d", cls, i), int'(obs),
             int'(exp_vec(ph[i], cls, v, mrq[i], z, ov)));
         @(posedge clk);
         #1;
      end
      if (cls != C_ILL) exp_ret = (exp_ret + 1) % (1 << CW);
      chk($sformatf("retired c%0d", cls), int'(retired), exp_ret);
   endtask

   initial begin
      rst = 1'b1;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset state", int'(state), 0);
      chk("reset retired", int'(retired), 0);
      chk("reset strobes", int'(obs), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_ret = 0;

      // Directed test-plan cases.
      run_instr(C_R, 0, 0, 0, 1'b0, 1'b0);
      run_instr(C_ADDI, 0, 0, 0, 1'b0, 1'b1);
      run_instr(C_LW, 0, 0, 2, 1'b0, 1'b1);
      run_instr(C_BEQ, 0, 0, 0, 1'b1, 1'b0);
      run_instr(C_BEQ, 0, 0, 0, 1'b0, 1'b0);
      run_instr(C_ILL, 0, 0, 0, 1'b0, 1'b0);
      run_instr(C_J, 0, 1, 0, 1'b0, 1'b0);
      run_instr(C_R, 1, 0, 0, 1'b0, 1'b1);
      run_instr(C_R, 4, 0, 0, 1'b0, 1'b1);
      run_instr(C_ORI, 0, 0, 0, 1'b0, 1'b1);
      run_instr(C_SW, 0, 2, 1, 1'b0, 1'b0);

      // Random mix; enough retirements to wrap the narrow counter several times.
      for (int n = 0; n < 200; n++) begin
         int cls;
         cls = int'($urandom_range(0, 7));
         run_instr(cls, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
      end

      // Reset during a stalled sw MEM phase.
      op = 6'b101011; funct = '0; mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("sw mem state", int'(state), 3);
      chk("sw mem_wr before rst", int'(mem_wr), 1);
      rst = 1'b1;
      #1;
      chk("mem_wr during rst", int'(mem_wr), 0);
      chk("strobes during rst", int'(obs), 0);
      @(posedge clk);
      #1;
      chk("state after rst", int'(state), 0);
      chk("retired after rst", int'(retired), 0);
      chk("mem_wr after rst edge", int'(mem_wr), 0);
      rst = 1'b0;
      exp_ret = 0;
      run_instr(C_SW, 0, 0, 0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
